// File: rtl/hex_display_scan_if.sv
// Bus between a value producer and the 8-digit hex display scanner:
// value/load/blank flow in, anode/segment drive and the frame pulse flow out.
interface hex_display_scan_if;
  logic [31:0] value;
  logic        load;
  logic        blank;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame;

  modport master (output value, load, blank, input an, seg, frame);
  modport slave  (input value, load, blank, output an, seg, frame);
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed 8-digit hex scanner for a common-anode 7-segment display.
// Anodes and segments are active-low; all outputs come straight from flops.
module hex_display_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  hex_display_scan_if.slave bus
);
  localparam int unsigned      CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [31:0]      shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_q, frame_d;
  logic             wrap_s;
  logic             dark_s;
  logic [31:0]      upper_s;

  // Shadow capture, refresh counter and digit index advance.
  always_comb begin
    if (bus.load) begin
      shadow_d = bus.value;
    end else begin
      shadow_d = shadow_q;
    end
    wrap_s = (cnt_q == CNT_LAST);
    if (wrap_s) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  // Output decode; upper_s holds nibbles idx..7, so it is zero exactly when the digit is a leading zero.
  always_comb begin
    upper_s = shadow_q >> {idx_q, 2'b00};
    dark_s  = LZ_BLANK && (idx_q != 3'd0) && (upper_s == 32'h0000_0000);
    frame_d = wrap_s && (idx_q == 3'd7);
    if (bus.blank || dark_s) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
    end else begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = hex_to_seg(upper_s[3:0]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= 32'h0000_0000;
      cnt_q    <= {CNT_W{1'b0}};
      idx_q    <= 3'd0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      frame_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.frame = frame_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: two instances (leading-zero blanking on/off) fed identically,
// checked every cycle against a scoreboard plus per-scenario spot checks.
`timescale 1ns/100ps
module tb_hex_display_scan;
  localparam int unsigned DIV = 4;

  typedef struct {
    logic [7:0] an_lz;
    logic [6:0] seg_lz;
    logic [7:0] an_all;
    logic [6:0] seg_all;
    logic       frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] value = 32'h0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        rst_exp;
  int unsigned k_m = 0;
  logic [31:0] sh_m = 32'h0;
  logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  hex_display_scan_if bus_lz ();
  hex_display_scan_if bus_all ();
  assign bus_lz.value  = value;
  assign bus_lz.load   = load;
  assign bus_lz.blank  = blank;
  assign bus_all.value = value;
  assign bus_all.load  = load;
  assign bus_all.blank = blank;

  hex_display_scan #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut_lz  (.clk(clk), .rst(rst), .bus(bus_lz.slave));
  hex_display_scan #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut_all (.clk(clk), .rst(rst), .bus(bus_all.slave));

  always #5 clk = ~clk;

  // Expected outputs after an edge, given k edges elapsed since reset release.
  function automatic exp_t exp_for(input int unsigned k, input logic [31:0] sh, input logic blk);
    exp_t        r;
    int unsigned d;
    logic [31:0] upper;
    d = (k / DIV) % 8;
    upper = sh >> (4 * d);
    r.frame = ((k + 1) % (8 * DIV)) == 0;
    r.an_all = 8'hFF; r.seg_all = 7'h7F; r.an_lz = 8'hFF; r.seg_lz = 7'h7F;
    if (!blk) begin
      r.an_all  = ~(8'h01 << d);
      r.seg_all = seg_tab[upper[3:0]];
      if (d == 0 || upper != 32'h0) begin
        r.an_lz  = r.an_all;
        r.seg_lz = r.seg_all;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_m <= 0;
      sh_m <= 32'h0;
      sb.delete();
    end else begin
      sb.push_back(exp_for(k_m, sh_m, blank));
      k_m <= k_m + 1;
      if (load) sh_m <= value;
    end
  end

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sb.size() != 0) e = sb.pop_front(); else e = rst_exp;
      n_tests++;
      if ({bus_lz.an, bus_lz.seg, bus_all.an, bus_all.seg, bus_lz.frame, bus_all.frame} !==
          {e.an_lz, e.seg_lz, e.an_all, e.seg_all, e.frame, e.frame}) begin
        n_fail++;
        $display("FAIL sb_reset t=%0t got an=%h/%h seg=%b/%b fr=%b/%b exp an=%h/%h seg=%b/%b fr=%b", $time,
                 bus_lz.an, bus_all.an, bus_lz.seg, bus_all.seg, bus_lz.frame, bus_all.frame,
                 e.an_lz, e.an_all, e.seg_lz, e.seg_all, e.frame);
      end
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus_lz.an !== 8'hFF || bus_lz.seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL first_cycle got an=%h seg=%b exp an=ff seg=1111111", bus_lz.an, bus_lz.seg);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sb.size() != 0) e = sb.pop_front(); else e = rst_exp;
      n_tests++;
      if ({bus_lz.an, bus_lz.seg, bus_all.an, bus_all.seg, bus_lz.frame, bus_all.frame} !==
          {e.an_lz, e.seg_lz, e.an_all, e.seg_all, e.frame, e.frame}) begin
        n_fail++;
        $display("FAIL sb_release t=%0t got an=%h/%h seg=%b/%b fr=%b/%b exp an=%h/%h seg=%b/%b fr=%b", $time,
                 bus_lz.an, bus_all.an, bus_lz.seg, bus_all.seg, bus_lz.frame, bus_all.frame,
                 e.an_lz, e.an_all, e.seg_lz, e.seg_all, e.frame);
      end
      if (i == 0) begin
        n_tests++;
        if (bus_lz.an !== 8'hFE || bus_lz.seg !== 7'b1000000) begin
          n_fail++;
          $display("FAIL digit0_after_reset got an=%h seg=%b exp an=fe seg=1000000", bus_lz.an, bus_lz.seg);
        end
      end
    end
  endtask

  task automatic test_load_a5();
    exp_t e;
    logic found = 1'b0;
    int win = 0, n0 = 0, n1 = 0, nff = 0, nfr = 0;
    value = 32'h0000_00A5;
    load = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (sb.size() != 0) e = sb.pop_front(); else e = rst_exp;
      n_tests++;
      if ({bus_lz.an, bus_lz.seg, bus_all.an, bus_all.seg, bus_lz.frame, bus_all.frame} !==
          {e.an_lz, e.seg_lz, e.an_all, e.seg_all, e.frame, e.frame}) begin
        n_fail++;
        $display("FAIL sb_load t=%0t got an=%h/%h seg=%b/%b fr=%b/%b exp an=%h/%h seg=%b/%b fr=%b", $time,
                 bus_lz.an, bus_all.an, bus_lz.seg, bus_all.seg, bus_lz.frame, bus_all.frame,
                 e.an_lz, e.an_all, e.seg_lz, e.seg_all, e.frame);
      end
      if (found) begin
        if (bus_lz.an === 8'hFE && bus_lz.seg === 7'b0010010) n0++;
        if (bus_lz.an === 8'hFD && bus_lz.seg === 7'b0001000) n1++;
        if (bus_lz.an === 8'hFF) nff++;
        if (bus_lz.frame === 1'b1) nfr++;
        win++;
        if (win == 32) break;
      end else if (e.frame) begin
        found = 1'b1;
      end
    end
    n_tests++;
    if (n0 != 4 || n1 != 4 || nff != 24 || nfr != 1) begin
      n_fail++;
      $display("FAIL rotation_a5 got d0=%0d d1=%0d dark=%0d frame=%0d exp 4 4 24 1", n0, n1, nff, nfr);
    end
  endtask

  task automatic test_lz_0123();
    exp_t e;
    logic [31:0] sh;
    logic found = 1'b0;
    int win = 0, ok_lz = 0, ok_all = 0, ff_lz = 0, d7_all = 0;
    value = 32'h0123_4567;
    load = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (sb.size() != 0) e = sb.pop_front(); else e = rst_exp;
      n_tests++;
      if ({bus_lz.an, bus_lz.seg, bus_all.an, bus_all.seg, bus_lz.frame, bus_all.frame} !==
          {e.an_lz, e.seg_lz, e.an_all, e.seg_all, e.frame, e.frame}) begin
        n_fail++;
        $display("FAIL sb_lz t=%0t got an=%h/%h seg=%b/%b fr=%b/%b exp an=%h/%h seg=%b/%b fr=%b", $time,
                 bus_lz.an, bus_all.an, bus_lz.seg, bus_all.seg, bus_lz.frame, bus_all.frame,
                 e.an_lz, e.an_all, e.seg_lz, e.seg_all, e.frame);
      end
      if (found) begin
        for (int d = 0; d < 8; d++) begin
          sh = 32'h0123_4567 >> (4 * d);
          if (bus_lz.an === ~(8'h01 << d) && bus_lz.seg === seg_tab[sh[3:0]]) ok_lz++;
          if (bus_all.an === ~(8'h01 << d) && bus_all.seg === seg_tab[sh[3:0]]) ok_all++;
        end
        if (bus_lz.an === 8'hFF) ff_lz++;
        if (bus_all.an === 8'h7F && bus_all.seg === 7'b1000000) d7_all++;
        win++;
        if (win == 32) break;
      end else if (e.frame) begin
        found = 1'b1;
      end
    end
    n_tests++;
    if (ok_lz != 28 || ff_lz != 4 || ok_all != 32 || d7_all != 4) begin
      n_fail++;
      $display("FAIL rotation_0123 got lit_lz=%0d dark_lz=%0d lit_all=%0d d7_all=%0d exp 28 4 32 4",
               ok_lz, ff_lz, ok_all, d7_all);
    end
  endtask

  task automatic test_inner_zero();
    exp_t e;
    logic [31:0] sh;
    logic found = 1'b0;
    int win = 0, ok_lz = 0, ff_lz = 0, d7_lz = 0;
    value = 32'h1000_0000;
    load = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (sb.size() != 0) e = sb.pop_front(); else e = rst_exp;
      n_tests++;
      if ({bus_lz.an, bus_lz.seg, bus_all.an, bus_all.seg, bus_lz.frame, bus_all.frame} !==
          {e.an_lz, e.seg_lz, e.an_all, e.seg_all, e.frame, e.frame}) begin
        n_fail++;
        $display("FAIL sb_inner t=%0t got an=%h/%h seg=%b/%b fr=%b/%b exp an=%h/%h seg=%b/%b fr=%b", $time,
                 bus_lz.an, bus_all.an, bus_lz.seg, bus_all.seg, bus_lz.frame, bus_all.frame,
                 e.an_lz, e.an_all, e.seg_lz, e.seg_all, e.frame);
      end
      if (found) begin
        for (int d = 0; d < 8; d++) begin
          sh = 32'h1000_0000 >> (4 * d);
          if (bus_lz.an === ~(8'h01 << d) && bus_lz.seg === seg_tab[sh[3:0]]) ok_lz++;
        end
        if (bus_lz.an === 8'hFF) ff_lz++;
        if (bus_lz.an === 8'h7F && bus_lz.seg === 7'b1111001) d7_lz++;
        win++;
        if (win == 32) break;
      end else if (e.frame) begin
        found = 1'b1;
      end
    end
    n_tests++;
    if (ok_lz != 32 || ff_lz != 0 || d7_lz != 4) begin
      n_fail++;
      $display("FAIL rotation_inner_zero got lit=%0d dark=%0d d7=%0d exp 32 0 4", ok_lz, ff_lz, d7_lz);
    end
  endtask

  task automatic test_blank();
    exp_t e;
    logic reached = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sb.size() != 0) e = sb.pop_front(); else e = rst_exp;
      n_tests++;
      if ({bus_lz.an, bus_lz.seg, bus_all.an, bus_all.seg, bus_lz.frame, bus_all.frame} !==
          {e.an_lz, e.seg_lz, e.an_all, e.seg_all, e.frame, e.frame}) begin
        n_fail++;
        $display("FAIL sb_blank_wait t=%0t got an=%h/%h seg=%b/%b fr=%b/%b exp an=%h/%h seg=%b/%b fr=%b", $time,
                 bus_lz.an, bus_all.an, bus_lz.seg, bus_all.seg, bus_lz.frame, bus_all.frame,
                 e.an_lz, e.an_all, e.seg_lz, e.seg_all, e.frame);
      end
      if (k_m % 32 == 13) begin
        reached = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!reached) begin
      n_fail++;
      $display("FAIL blank_position got timeout exp digit 3 within 64 cycles");
    end
    blank = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 10) blank = 1'b0;
      if (sb.size() != 0) e = sb.pop_front(); else e = rst_exp;
      n_tests++;
      if ({bus_lz.an, bus_lz.seg, bus_all.an, bus_all.seg, bus_lz.frame, bus_all.frame} !==
          {e.an_lz, e.seg_lz, e.an_all, e.seg_all, e.frame, e.frame}) begin
        n_fail++;
        $display("FAIL sb_blank t=%0t got an=%h/%h seg=%b/%b fr=%b/%b exp an=%h/%h seg=%b/%b fr=%b", $time,
                 bus_lz.an, bus_all.an, bus_lz.seg, bus_all.seg, bus_lz.frame, bus_all.frame,
                 e.an_lz, e.an_all, e.seg_lz, e.seg_all, e.frame);
      end
      if (i <= 10) begin
        n_tests++;
        if (bus_all.an !== 8'hFF || bus_all.seg !== 7'h7F || bus_lz.an !== 8'hFF) begin
          n_fail++;
          $display("FAIL blank_dark cycle %0d got an=%h/%h seg=%b exp an=ff seg=1111111", i, bus_lz.an, bus_all.an, bus_all.seg);
        end
      end
      if (i == 12) begin
        n_tests++;
        if (bus_lz.an !== 8'hBF || bus_lz.seg !== 7'b1000000) begin
          n_fail++;
          $display("FAIL blank_resume got an=%h seg=%b exp an=bf seg=1000000", bus_lz.an, bus_lz.seg);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic reached = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sb.size() != 0) e = sb.pop_front(); else e = rst_exp;
      n_tests++;
      if ({bus_lz.an, bus_lz.seg, bus_all.an, bus_all.seg, bus_lz.frame, bus_all.frame} !==
          {e.an_lz, e.seg_lz, e.an_all, e.seg_all, e.frame, e.frame}) begin
        n_fail++;
        $display("FAIL sb_rst_wait t=%0t got an=%h/%h seg=%b/%b fr=%b/%b exp an=%h/%h seg=%b/%b fr=%b", $time,
                 bus_lz.an, bus_all.an, bus_lz.seg, bus_all.seg, bus_lz.frame, bus_all.frame,
                 e.an_lz, e.an_all, e.seg_lz, e.seg_all, e.frame);
      end
      if (k_m % 32 == 22) begin
        reached = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!reached) begin
      n_fail++;
      $display("FAIL reset_position got timeout exp digit 5 within 64 cycles");
    end
    #3 rst = 1'b0;
    #0.5;
    n_tests++;
    if (bus_lz.an !== 8'hFF || bus_all.an !== 8'hFF || bus_all.seg !== 7'h7F || bus_lz.frame !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got an=%h/%h seg=%b fr=%b exp an=ff seg=1111111 fr=0",
               bus_lz.an, bus_all.an, bus_all.seg, bus_lz.frame);
    end
    #0.5 rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() != 0) e = sb.pop_front(); else e = rst_exp;
      n_tests++;
      if ({bus_lz.an, bus_lz.seg, bus_all.an, bus_all.seg, bus_lz.frame, bus_all.frame} !==
          {e.an_lz, e.seg_lz, e.an_all, e.seg_all, e.frame, e.frame}) begin
        n_fail++;
        $display("FAIL sb_rst_mid t=%0t got an=%h/%h seg=%b/%b fr=%b/%b exp an=%h/%h seg=%b/%b fr=%b", $time,
                 bus_lz.an, bus_all.an, bus_lz.seg, bus_all.seg, bus_lz.frame, bus_all.frame,
                 e.an_lz, e.an_all, e.seg_lz, e.seg_all, e.frame);
      end
      if (i == 0 || i == 4) begin
        n_tests++;
        if (bus_lz.an !== ((i == 0) ? 8'hFE : 8'hFF) || bus_all.seg !== 7'b1000000) begin
          n_fail++;
          $display("FAIL restart_digit cycle %0d got an=%h seg=%b exp shadow cleared, scan from digit 0", i, bus_lz.an, bus_all.seg);
        end
      end
    end
  endtask

  initial begin
    rst_exp = '{an_lz: 8'hFF, seg_lz: 7'h7F, an_all: 8'hFF, seg_all: 7'h7F, frame: 1'b0};
    test_reset();
    test_load_a5();
    test_lz_0123();
    test_inner_zero();
    test_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got time limit reached exp bench to finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Downstream consumer of the 32-bit counter.
- Captures a 32-bit value and time-multiplexes it as 8 hex digits onto a common-anode 7-segment display (active-low anodes and segments).
- Provides leading-zero blanking, a global blank input, and a frame-start pulse so upstream logic can align value updates to display refresh.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays lit (1 kHz/digit at 100 MHz); legal range 1..2^20
LZ_BLANK, 1, 1 = suppress leading zero digits (digit 0 always shown); 0 = show all 8 digits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
value  input  32  value to display; nibble i drives digit i (digit 0 = value[3:0], rightmost)
load  input  1  capture strobe; value sampled into shadow register on any clk edge with load=1
blank  input  1  1 = all digits dark; scanning continues
an  output  8  digit enables, active-low, an[i] = digit i
seg  output  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a
frame  output  1  one-cycle pulse when scan wraps from digit 7 to digit 0

Behaviour:
- Reset (rst=0, asynchronous): shadow=0, refresh counter=0, digit index=0, an=8'hFF, seg=7'h7F, frame=0. All outputs are registered.
- Shadow register:
  - load=1 at an edge captures value; otherwise the shadow holds.
  - Display always uses the shadow, never value directly.
  - A new value appears on the next registered output update, 1 cycle after capture.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and the digit index advances by 1 mod 8 (7 -> 0).
  - REFRESH_DIV=1: index advances every cycle.
- frame:
  - Asserted for exactly one cycle, registered, in the cycle the index transitions 7 -> 0.
  - Never asserted in the first scan after reset. The index starts at 0 without a wrap.
- Output registers update every cycle from the current index and shadow (1-cycle latency):
  - blank=1: an=8'hFF, seg=7'h7F.
  - Digit blanked: LZ_BLANK=1 and idx>0 and shadow nibbles idx..7 all zero. Then an=8'hFF, seg=7'h7F.
  - Otherwise: an = all ones except an[idx]=0, and seg = decode(shadow nibble idx).
  - First cycle after reset release: an=8'hFF. From cycle 2, digit 0 is lit.
- Decode table, seg[6:0] as g..a, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- At most one an bit is low in any cycle. No glitch cycle with two digits enabled is permitted.
- Simultaneous events:
  - load coincident with a digit advance: the new digit shows the newly captured shadow in the following cycle.
  - blank toggling mid-digit takes effect on the next cycle and does not disturb the counter or index.
- Reset mid-scan: immediate return to reset values. Scan restarts at digit 0 with the counter at 0.

Test Plan (REFRESH_DIV=4 in sim):
- Reset held 100 ns, then released. Expected: an=FF, seg=7F during reset and on the first cycle after release; then an=FE with seg=1000000 (value 0, digit 0 only, others blanked by LZ_BLANK).
- load=1 for one cycle with value=32'h0000_00A5. Expected:
  - digit 0 (an=FE) shows 0010010 ("5") for 4 cycles;
  - digit 1 (an=FD) shows 0001000 ("A");
  - digits 2..7 give an=FF;
  - full rotation is 32 cycles, with frame high 1 cycle at the 7 -> 0 wrap.
- value=32'h0123_4567 loaded, LZ_BLANK=1. Expected: digit 7 dark (an=FF in its slot); digits 6..0 show 1,2,...,7. Rerun with LZ_BLANK=0: digit 7 shows 1000000.
- value=32'h1000_0000. Expected: digits 1..6 lit with "0" (not leading), digit 7 shows 1111001.
- blank=1 for 10 cycles mid-digit-3. Expected: an=FF, seg=7F throughout. On release, the scan index matches an unblanked reference run, so the counter did not stall.
- rst pulsed low for 1 ns mid-digit-5, asynchronous to clk. Expected: outputs go to FF/7F immediately without waiting for clk, shadow=0, and the scan restarts at digit 0.
